icap_stream_writer: RTL and testbench
=====================================

# icap_stream_writer

Consumes the 16-bit `user_w_icap_in` write stream that `xillybus_core` produces and drives the Spartan-6 ICAP configuration port. It buffers words in a small FIFO, applies per-byte bit reversal for the ICAP, and paces issue against ICAP BUSY. It also tracks session state from the `open` signal so host-driven reconfiguration is bounded, counted and error-flagged.

## Interface
- `FIFO_AW`, default 4: FIFO address width; depth = 2^FIFO_AW words.
- `BIT_SWAP`, default 1: 1 = reverse bit order within each byte before ICAP; 0 = pass through.
- `bus_clk`  in  1  single clock, same domain as the `xillybus_core` user interface.
- `bus_rst_n`  in  1  reset, asynchronous assert, active-low; deassertion arrives synchronised to `bus_clk`.
- `user_w_icap_in_data`  in  16  write data from the core.
- `user_w_icap_in_wren`  in  1  write strobe; one word per cycle.
- `user_w_icap_in_open`  in  1  host file open (level).
- `user_w_icap_in_full`  out  1  FIFO full, back to the core.
- `icap_i`  out  16  ICAP data input, registered.
- `icap_ce_n`  out  1  ICAP chip enable, active-low, registered.
- `icap_write_n`  out  1  ICAP WRITE, 0 = write, registered.
- `icap_busy`  in  1  ICAP BUSY.
- `words_written`  out  32  words issued to ICAP this session.
- `err_overflow`  out  1  sticky: a write was attempted while full.
- `active`  out  1  state is not IDLE.

## Operation
- **FIFO.** Depth 2^FIFO_AW, occupancy counter FIFO_AW+1 bits wide.
  - `full` = (count == depth), driven combinationally from the count register.
  - Push when `wren && !full`. This is legal in every state, so words written before RUN wait in the FIFO.
  - `wren && full`: the word is dropped and `err_overflow` is set.
- **State machine**, states IDLE / RUN / DRAIN.
  - **IDLE.** `icap_ce_n`=1, `icap_write_n`=1, no pops. If `open`=1, go to RUN. The entry edge clears `words_written` and `err_overflow` and sets `icap_write_n`=0.
  - **RUN.** On each cycle with FIFO non-empty and `icap_busy`=0: pop, register `icap_i`=swap(word), drive `icap_ce_n`=0 for that cycle, and increment `words_written`. Otherwise `icap_ce_n`=1 and `icap_i` holds. If `open`=0, go to DRAIN.
  - **DRAIN.** Same issue rule as RUN. When the FIFO is empty and no pop occurs this cycle, go to IDLE; `icap_write_n` returns to 1 one cycle after the final CE pulse. `open` re-asserting during DRAIN is ignored until IDLE, then re-enters RUN through the clearing path.
- **Bit swap.** With `BIT_SWAP`=1, `icap_i[8b+k]` = `data[8b+7-k]` for b∈{0,1}, k∈0..7. Byte order is not changed.
- **Counter.** `words_written` is 32-bit and wraps 0xFFFFFFFF→0. `err_overflow` clears only on IDLE→RUN or reset.
- **Simultaneous push and pop at full.** The push is rejected because full is sampled from the registered count; the pop proceeds. The count becomes depth-1.
- **Simultaneous push and pop at non-full.** Count is unchanged.
- **Reset, including mid-session.** State→IDLE, FIFO emptied, `icap_ce_n`=1, `icap_write_n`=1, `icap_i`=0, `user_w_icap_in_full`=0, `words_written`=0, `err_overflow`=0, `active`=0.

## Timing
- **Write to CE latency.** A word pushed at edge E0 in RUN gives `icap_ce_n`=0 after E1, so the ICAP samples it at E2. Latency is 1 cycle.
- **Throughput.** One word per cycle sustained; `full` never asserts while RUN issues without BUSY.
- **WRITE before CE.** `icap_write_n` goes low at least one cycle before the first `icap_ce_n`=0 of a session, because a pop is never taken in the IDLE→RUN cycle.
- **BUSY.** `icap_busy` is sampled at the edge that decides the pop. Busy=1 holds the pop, giving one bubble minimum. Data and CE change only on edges.
- **full.** `full` rises in the cycle after the push that fills the FIFO. It falls in the cycle after the first pop.

## Test plan
- **Basic stream.** Reset, open=1, write 0x0180, 0xAA99 back-to-back → `icap_i`=0x8001 then 0x5599 on consecutive CE-low cycles; `words_written`=2; `icap_write_n` low from the cycle after open.
- **Pass-through.** Same sequence with `BIT_SWAP`=0 → `icap_i`=0x0180, 0xAA99.
- **BUSY back-pressure.** Hold `icap_busy`=1, write 16 words (FIFO_AW=4) → `full`=1, no CE. Write a 17th → `err_overflow`=1, word dropped. Release busy → 16 CE pulses, data in order.
- **Close with backlog.** Hold busy, write 5 words, drop open, release busy → 5 CE pulses, `active` falls one cycle after the last pulse, `icap_write_n`=1.
- **Mid-session reset.** Assert reset while FIFO holds 3 words → all outputs at reset values immediately. After release with open=1 → state RUN, `words_written`=0, no stale words issued.
- **Counter wrap.** Force `words_written`=0xFFFFFFFF and issue one word → value becomes 0x00000000.

Source files
------------

// File: rtl/icap_stream_writer.sv
// ICAP write-stream adapter: buffers 16-bit words from the Xillybus write pipe,
// bit-reverses each byte, and issues words to the Spartan-6 ICAP while it is not BUSY.
module icap_stream_writer #(
  parameter int FIFO_AW  = 4,
  parameter bit BIT_SWAP = 1'b1
) (
  input  logic        bus_clk,
  input  logic        bus_rst_n,
  input  logic [15:0] user_w_icap_in_data,
  input  logic        user_w_icap_in_wren,
  input  logic        user_w_icap_in_open,
  output logic        user_w_icap_in_full,
  output logic [15:0] icap_i,
  output logic        icap_ce_n,
  output logic        icap_write_n,
  input  logic        icap_busy,
  output logic [31:0] words_written,
  output logic        err_overflow,
  output logic        active
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             r_state;
  logic [15:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic [15:0]        r_icap_i;
  logic               r_ce_n;
  logic               r_write_n;
  logic [31:0]        r_words_written;
  logic               r_err_overflow;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [15:0]        w_rd_data;
  logic [15:0]        w_swapped;

  // Full comes from the registered count, so a push at full is rejected even if a pop happens.
  assign w_full    = (r_count == DEPTH_C);
  assign w_empty   = (r_count == '0);
  assign w_push    = user_w_icap_in_wren & ~w_full;
  assign w_pop     = (r_state != S_IDLE) & ~w_empty & ~icap_busy;
  assign w_rd_data = r_mem[r_rd_ptr];

  always_comb begin
    // NOTE: assign a full default first so no path through this block infers a latch.
    w_swapped = w_rd_data;
    if (BIT_SWAP) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < 8; k++) begin
          w_swapped[8*b+k] = w_rd_data[8*b+7-k];
        end
      end
    end
  end

  // NOTE: storage array has no reset; pointers and count define validity, which keeps it in RAM.
  always_ff @(posedge bus_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= user_w_icap_in_data;
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: all state here uses non-blocking assignment so every register updates from pre-edge values.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      r_state         <= S_IDLE;
      r_icap_i        <= '0;
      r_ce_n          <= 1'b1;
      r_write_n       <= 1'b1;
      r_words_written <= '0;
      r_err_overflow  <= 1'b0;
    end else begin
      r_ce_n <= 1'b1;
      if (w_pop) begin
        r_ce_n          <= 1'b0;
        r_icap_i        <= w_swapped;
        r_words_written <= r_words_written + 32'd1;
      end

      case (r_state)
        S_IDLE: begin
          r_write_n <= 1'b1;
          if (user_w_icap_in_open) begin
            r_state         <= S_RUN;
            r_write_n       <= 1'b0;
            r_words_written <= '0;
            r_err_overflow  <= 1'b0;
          end
        end
        S_RUN: begin
          if (!user_w_icap_in_open) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Empty means no pop this cycle; WRITE rises as the last CE pulse ends.
          if (w_empty) begin
            r_state   <= S_IDLE;
            r_write_n <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (user_w_icap_in_wren && w_full) r_err_overflow <= 1'b1;
    end
  end

  assign user_w_icap_in_full = w_full;
  assign icap_i              = r_icap_i;
  assign icap_ce_n           = r_ce_n;
  assign icap_write_n        = r_write_n;
  assign words_written       = r_words_written;
  assign err_overflow        = r_err_overflow;
  assign active              = (r_state != S_IDLE);

endmodule

// File: tb/tb_icap_stream_writer.sv
// Scoreboard bench for icap_stream_writer: a bit-swapping and a pass-through instance
// share one stimulus stream; each CE-low cycle is checked against queued expected words.
module tb_icap_stream_writer;

  logic        bus_clk = 1'b0;
  logic        bus_rst_n = 1'b0;
  logic [15:0] user_w_icap_in_data = '0;
  logic        user_w_icap_in_wren = 1'b0;
  logic        user_w_icap_in_open = 1'b0;
  logic        icap_busy = 1'b0;

  logic        full1, ce_n1, write_n1, err1, active1;
  logic [15:0] icap_i1;
  logic [31:0] words1;
  logic        full0, ce_n0, write_n0, err0, active0;
  logic [15:0] icap_i0;
  logic [31:0] words0;

  int n_checks = 0;
  int n_fail   = 0;
  int ce_pulses = 0;
  logic [15:0] q1[$];
  logic [15:0] q0[$];

  always #5 bus_clk = ~bus_clk;

  icap_stream_writer #(.FIFO_AW(4), .BIT_SWAP(1'b1)) dut1 (
    .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
    .user_w_icap_in_data(user_w_icap_in_data), .user_w_icap_in_wren(user_w_icap_in_wren),
    .user_w_icap_in_open(user_w_icap_in_open), .user_w_icap_in_full(full1),
    .icap_i(icap_i1), .icap_ce_n(ce_n1), .icap_write_n(write_n1), .icap_busy(icap_busy),
    .words_written(words1), .err_overflow(err1), .active(active1)
  );

  icap_stream_writer #(.FIFO_AW(4), .BIT_SWAP(1'b0)) dut0 (
    .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
    .user_w_icap_in_data(user_w_icap_in_data), .user_w_icap_in_wren(user_w_icap_in_wren),
    .user_w_icap_in_open(user_w_icap_in_open), .user_w_icap_in_full(full0),
    .icap_i(icap_i0), .icap_ce_n(ce_n0), .icap_write_n(write_n0), .icap_busy(icap_busy),
    .words_written(words0), .err_overflow(err0), .active(active0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] swap_bytes_bits(input logic [15:0] d);
    logic [7:0] hi, lo;
    hi = d[15:8];
    lo = d[7:0];
    return {{<<{hi}}, {<<{lo}}};
  endfunction

  task automatic write_word(input logic [15:0] d, input bit accept);
    user_w_icap_in_data = d;
    user_w_icap_in_wren = 1'b1;
    if (accept) begin
      q1.push_back(swap_bytes_bits(d));
      q0.push_back(d);
    end
    @(posedge bus_clk); #1;
    user_w_icap_in_wren = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge bus_clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while ((q1.size() != 0 || q0.size() != 0) && t < budget) begin
      @(posedge bus_clk); t++;
    end
    #1;
    check("drain_timeout", 32'(q1.size() + q0.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_full"},    {31'd0, full1},    32'd0);
    check({tag, "_ce_n"},    {31'd0, ce_n1},    32'd1);
    check({tag, "_write_n"}, {31'd0, write_n1}, 32'd1);
    check({tag, "_icap_i"},  {16'd0, icap_i1},  32'd0);
    check({tag, "_words"},   words1,            32'd0);
    check({tag, "_err"},     {31'd0, err1},     32'd0);
    check({tag, "_active"},  {31'd0, active1},  32'd0);
    check({tag, "_ce_n_p"},  {31'd0, ce_n0},    32'd1);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge bus_clk) begin
    if (bus_rst_n && !ce_n1) begin
      ce_pulses++;
      if (q1.size() == 0) check("unexpected_ce_swap", 32'd1, 32'd0);
      else check("icap_i_swap", {16'd0, icap_i1}, {16'd0, q1.pop_front()});
      check("write_n_during_ce", {31'd0, write_n1}, 32'd0);
    end
    if (bus_rst_n && !ce_n0) begin
      if (q0.size() == 0) check("unexpected_ce_pass", 32'd1, 32'd0);
      else check("icap_i_pass", {16'd0, icap_i0}, {16'd0, q0.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int n;
    logic [15:0] d;

    // Reset state
    #12;
    check_reset_values("reset");
    @(posedge bus_clk); #1;
    bus_rst_n = 1'b1;
    cycles(2);
    check("idle_active", {31'd0, active1}, 32'd0);

    // Basic stream
    user_w_icap_in_open = 1'b1;
    cycles(1);
    check("open_write_n", {31'd0, write_n1}, 32'd0);
    check("open_active",  {31'd0, active1},  32'd1);
    check("open_ce_n",    {31'd0, ce_n1},    32'd1);
    write_word(16'h0180, 1'b1);
    write_word(16'hAA99, 1'b1);
    check("latency_ce_n", {31'd0, ce_n1}, 32'd0);
    check("first_word",   {16'd0, icap_i1}, 32'h8001);
    cycles(1);
    check("second_ce_n",  {31'd0, ce_n1}, 32'd0);
    check("second_word",  {16'd0, icap_i1}, 32'h5599);
    cycles(1);
    check("after_ce_n",   {31'd0, ce_n1}, 32'd1);
    check("basic_words",  words1, 32'd2);
    check("basic_words_p", words0, 32'd2);
    wait_drain(10);

    // BUSY back-pressure and overflow
    icap_busy = 1'b1;
    snap = ce_pulses;
    for (int i = 0; i < 16; i++) write_word(16'($urandom), 1'b1);
    check("busy_full", {31'd0, full1}, 32'd1);
    check("busy_err_pre", {31'd0, err1}, 32'd0);
    write_word(16'hDEAD, 1'b0);
    check("overflow_err", {31'd0, err1}, 32'd1);
    check("overflow_err_p", {31'd0, err0}, 32'd1);
    check("busy_no_ce", 32'(ce_pulses), 32'(snap));
    icap_busy = 1'b0;
    cycles(1);
    check("full_falls", {31'd0, full1}, 32'd0);
    check("release_ce_n", {31'd0, ce_n1}, 32'd0);
    wait_drain(40);
    cycles(2);
    check("busy_pulses", 32'(ce_pulses - snap), 32'd16);
    check("busy_words", words1, 32'd18);
    check("err_sticky", {31'd0, err1}, 32'd1);

    // Close with backlog
    icap_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = 16'h1357 + 16'(i);
      write_word(d, 1'b1);
    end
    user_w_icap_in_open = 1'b0;
    cycles(2);
    check("drain_active", {31'd0, active1}, 32'd1);
    icap_busy = 1'b0;
    n = 0;
    for (int t = 0; t < 40 && n < 5; t++) begin
      @(posedge bus_clk); #1;
      if (!ce_n1) n++;
    end
    check("drain_pulses", 32'(n), 32'd5);
    check("last_pulse_active", {31'd0, active1}, 32'd1);
    cycles(1);
    check("drain_done_active", {31'd0, active1}, 32'd0);
    check("drain_done_write_n", {31'd0, write_n1}, 32'd1);
    check("drain_done_ce_n", {31'd0, ce_n1}, 32'd1);
    check("drain_words", words1, 32'd23);
    check("drain_queue", 32'(q1.size()), 32'd0);

    // Mid-session reset
    user_w_icap_in_open = 1'b1;
    cycles(1);
    check("reopen_active", {31'd0, active1}, 32'd1);
    check("reopen_words", words1, 32'd0);
    check("reopen_err", {31'd0, err1}, 32'd0);
    icap_busy = 1'b1;
    for (int i = 0; i < 3; i++) write_word(16'h0F00 + 16'(i), 1'b1);
    #2 bus_rst_n = 1'b0;
    #1 check_reset_values("midreset");
    q1.delete();
    q0.delete();
    icap_busy = 1'b0;
    @(posedge bus_clk); #1;
    bus_rst_n = 1'b1;
    snap = ce_pulses;
    cycles(1);
    check("post_reset_active", {31'd0, active1}, 32'd1);
    check("post_reset_write_n", {31'd0, write_n1}, 32'd0);
    cycles(5);
    check("post_reset_words", words1, 32'd0);
    check("post_reset_no_ce", 32'(ce_pulses), 32'(snap));

    // Counter wrap
    @(negedge bus_clk);
    force dut1.r_words_written = 32'hFFFF_FFFF;
    force dut0.r_words_written = 32'hFFFF_FFFF;
    #1;
    release dut1.r_words_written;
    release dut0.r_words_written;
    #1 check("wrap_preload", words1, 32'hFFFF_FFFF);
    @(posedge bus_clk); #1;
    write_word(16'h4321, 1'b1);
    cycles(3);
    check("wrap_words", words1, 32'd0);
    check("wrap_words_p", words0, 32'd0);
    wait_drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
